// File: rtl/pixel_stream_proc.sv
// pixel_stream_proc: two-stage RGB pixel processor on a valid/ready stream.
// S1 captures the pixel with its mode/operand and computes gray; S2 applies
// the selected mode, registers the result, and keeps per-frame pixel counts.
module pixel_stream_proc #(
  parameter int PIX_W = 8,
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       sel_mod,
  input  logic [PIX_W-1:0] val,
  input  logic [2:0]       ch_mask,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [PIX_W-1:0] red,
  input  logic [PIX_W-1:0] green,
  input  logic [PIX_W-1:0] blue,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [PIX_W-1:0] red_o,
  output logic [PIX_W-1:0] green_o,
  output logic [PIX_W-1:0] blue_o,
  output logic             frame_done,
  output logic [CNT_W-1:0] px_count
);

  typedef enum logic [2:0] {
    MODE_GRAY   = 3'b000,
    MODE_BRIGHT = 3'b001,
    MODE_DARK   = 3'b010,
    MODE_INVERT = 3'b011,
    MODE_THRESH = 3'b100,
    MODE_MASK   = 3'b101,
    MODE_SWAP   = 3'b110,
    MODE_PASS   = 3'b111
  } mode_e;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } rgb_t;

  localparam int               GRAY_W  = PIX_W + 9;
  localparam logic [PIX_W-1:0] MAXV    = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating add: the carry out of the PIX_W+1-bit sum selects MAXV.
  function automatic logic [PIX_W-1:0] sat_add(input logic [PIX_W-1:0] c,
                                               input logic [PIX_W-1:0] v);
    logic [PIX_W:0] s;
    s = {1'b0, c} + {1'b0, v};
    return s[PIX_W] ? MAXV : s[PIX_W-1:0];
  endfunction

  // Floor-at-zero subtract, decided by compare so it never wraps.
  function automatic logic [PIX_W-1:0] sat_sub(input logic [PIX_W-1:0] c,
                                               input logic [PIX_W-1:0] v);
    return (c >= v) ? (c - v) : '0;
  endfunction

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic             s1_last_q, s1_last_d;
  mode_e            s1_mode_q, s1_mode_d;
  logic [PIX_W-1:0] s1_val_q, s1_val_d;
  logic [2:0]       s1_mask_q, s1_mask_d;
  rgb_t             s1_px_q, s1_px_d;
  logic [PIX_W-1:0] s1_gray_q, s1_gray_d;

  // Stage 2 / output state
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  rgb_t             out_px_q, out_px_d;
  logic             frame_done_q, frame_done_d;
  logic [CNT_W-1:0] px_count_q, px_count_d;
  logic [CNT_W-1:0] running_q, running_d;

  logic             adv;
  logic [GRAY_W-1:0] gray_sum;
  rgb_t             mode_res;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  // Luma weights sum to 256, so the shifted sum always fits in PIX_W bits.
  always_comb begin
    gray_sum = GRAY_W'(77) * GRAY_W'(red) + GRAY_W'(150) * GRAY_W'(green)
             + GRAY_W'(29) * GRAY_W'(blue);
  end

  // S1: capture pixel plus its per-pixel controls; hold when the output stalls.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    s1_mode_d  = s1_mode_q;
    s1_val_d   = s1_val_q;
    s1_mask_d  = s1_mask_q;
    s1_px_d    = s1_px_q;
    s1_gray_d  = s1_gray_q;
    if (adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_last_d = in_last;
        s1_mode_d = mode_e'(sel_mod);
        s1_val_d  = val;
        s1_mask_d = ch_mask;
        s1_px_d   = '{r: red, g: green, b: blue};
        s1_gray_d = gray_sum[PIX_W+7:8];
      end
    end
  end

  // Mode mux on the S1 contents, so each pixel uses the mode it arrived with.
  always_comb begin
    mode_res = s1_px_q;
    unique case (s1_mode_q)
      MODE_GRAY:   mode_res = '{r: s1_gray_q, g: s1_gray_q, b: s1_gray_q};
      MODE_BRIGHT: mode_res = '{r: sat_add(s1_px_q.r, s1_val_q),
                                g: sat_add(s1_px_q.g, s1_val_q),
                                b: sat_add(s1_px_q.b, s1_val_q)};
      MODE_DARK:   mode_res = '{r: sat_sub(s1_px_q.r, s1_val_q),
                                g: sat_sub(s1_px_q.g, s1_val_q),
                                b: sat_sub(s1_px_q.b, s1_val_q)};
      MODE_INVERT: mode_res = '{r: MAXV - s1_px_q.r, g: MAXV - s1_px_q.g,
                                b: MAXV - s1_px_q.b};
      MODE_THRESH: begin
        mode_res.r = (s1_gray_q >= s1_val_q) ? MAXV : '0;
        mode_res.g = mode_res.r;
        mode_res.b = mode_res.r;
      end
      MODE_MASK:   mode_res = '{r: s1_mask_q[2] ? s1_px_q.r : '0,
                                g: s1_mask_q[1] ? s1_px_q.g : '0,
                                b: s1_mask_q[0] ? s1_px_q.b : '0};
      MODE_SWAP:   mode_res = '{r: s1_px_q.b, g: s1_px_q.g, b: s1_px_q.r};
      MODE_PASS:   mode_res = s1_px_q;
    endcase
  end

  // S2 load and frame counting; data only changes when a real pixel lands.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_px_d     = out_px_q;
    running_d    = running_q;
    px_count_d   = px_count_q;
    frame_done_d = 1'b0;
    if (adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_last_d = s1_last_q;
        out_px_d   = mode_res;
      end
    end
    if (out_valid_q && out_ready) begin
      running_d = (running_q == CNT_MAX) ? running_q : running_q + CNT_W'(1);
      if (out_last_q) begin
        px_count_d   = running_d;
        frame_done_d = 1'b1;
        running_d    = '0;
      end
    end
  end

  // All state registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_mode_q    <= MODE_GRAY;
      s1_val_q     <= '0;
      s1_mask_q    <= '0;
      s1_px_q      <= '0;
      s1_gray_q    <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_px_q     <= '0;
      frame_done_q <= 1'b0;
      px_count_q   <= '0;
      running_q    <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_last_q    <= s1_last_d;
      s1_mode_q    <= s1_mode_d;
      s1_val_q     <= s1_val_d;
      s1_mask_q    <= s1_mask_d;
      s1_px_q      <= s1_px_d;
      s1_gray_q    <= s1_gray_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_px_q     <= out_px_d;
      frame_done_q <= frame_done_d;
      px_count_q   <= px_count_d;
      running_q    <= running_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign red_o      = out_px_q.r;
  assign green_o    = out_px_q.g;
  assign blue_o     = out_px_q.b;
  assign frame_done = frame_done_q;
  assign px_count   = px_count_q;

endmodule

// File: tb/tb_pixel_stream_proc.sv
// tb_pixel_stream_proc: directed scoreboard bench for pixel_stream_proc (PIX_W=8).
module tb_pixel_stream_proc;

  localparam int PIX_W = 8;
  localparam int CNT_W = 20;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [2:0]       sel_mod = '0;
  logic [PIX_W-1:0] val = '0;
  logic [2:0]       ch_mask = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_last = 1'b0;
  logic [PIX_W-1:0] red = '0, green = '0, blue = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_last;
  logic [PIX_W-1:0] red_o, green_o, blue_o;
  logic             frame_done;
  logic [CNT_W-1:0] px_count;

  pixel_stream_proc #(.PIX_W(PIX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .sel_mod(sel_mod), .val(val), .ch_mask(ch_mask),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .red(red), .green(green), .blue(blue),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
    .frame_done(frame_done), .px_count(px_count)
  );

  always #5 clk = ~clk;

  typedef logic [3*PIX_W:0] px_t;  // {last, r, g, b}
  px_t sb[$];

  int   n_checks = 0, n_pass = 0, n_fail = 0;
  int   cyc = 0, stall_lo = 0, stall_hi = 0, fd_count = 0;
  bit   acc = 1'b0, was_stall = 1'b0;
  px_t  held = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour, computed in plain integers.
  function automatic px_t model(input logic [2:0] m, input int v, input logic [2:0] k,
                                input int r, input int g, input int b, input logic l);
    int gray, orr, og, ob;
    gray = (77 * r + 150 * g + 29 * b) / 256;
    case (m)
      3'b000: begin orr = gray; og = gray; ob = gray; end
      3'b001: begin
        orr = (r + v > 255) ? 255 : r + v;
        og  = (g + v > 255) ? 255 : g + v;
        ob  = (b + v > 255) ? 255 : b + v;
      end
      3'b010: begin
        orr = (r >= v) ? r - v : 0;
        og  = (g >= v) ? g - v : 0;
        ob  = (b >= v) ? b - v : 0;
      end
      3'b011: begin orr = 255 - r; og = 255 - g; ob = 255 - b; end
      3'b100: begin orr = (gray >= v) ? 255 : 0; og = orr; ob = orr; end
      3'b101: begin orr = k[2] ? r : 0; og = k[1] ? g : 0; ob = k[0] ? b : 0; end
      3'b110: begin orr = b; og = g; ob = r; end
      default: begin orr = r; og = g; ob = b; end
    endcase
    return {l, orr[7:0], og[7:0], ob[7:0]};
  endfunction

  // One clock: decide handshakes at the negedge, score outputs, step past posedge.
  task automatic cycle();
    out_ready = !(cyc >= stall_lo && cyc < stall_hi);
    @(negedge clk);
    acc = in_valid && in_ready;
    if (acc)
      sb.push_back(model(sel_mod, int'(val), ch_mask, int'(red), int'(green), int'(blue), in_last));
    if (frame_done) fd_count++;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL sb_underflow: observed an output pixel, expected none pending");
      end else begin
        check("px_out", 32'({out_last, red_o, green_o, blue_o}), 32'(sb.pop_front()));
      end
    end
    if (out_valid && !out_ready) begin
      check("stall_in_ready", 32'(in_ready), 32'd0);
      if (was_stall)
        check("stall_hold", 32'({out_last, red_o, green_o, blue_o}), 32'(held));
      held      = {out_last, red_o, green_o, blue_o};
      was_stall = 1'b1;
    end else begin
      was_stall = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present one pixel and hold it until accepted.
  task automatic send(input logic [2:0] m, input logic [7:0] v, input logic [2:0] k,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic l);
    int n;
    n = 0;
    sel_mod = m; val = v; ch_mask = k; red = r; green = g; blue = b; in_last = l;
    in_valid = 1'b1;
    do begin
      cycle();
      n++;
    end while (!acc && n < 20);
    if (!acc) begin
      n_checks++;
      n_fail++;
      $error("FAIL send_timeout: observed no input handshake in %0d cycles, expected one", n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (sb.size() > 0 && n < 50) begin
      cycle();
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Single pixel into an empty pipe: invisible one cycle after handshake, visible after two.
  task automatic direct(input string tag, input logic [2:0] m, input logic [7:0] v,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic [23:0] exp_rgb);
    send(m, v, 3'b000, r, g, b, 1'b0);
    in_valid = 1'b0;
    check({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
    cycle();
    check({tag, "_lat2_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_rgb"}, 32'({red_o, green_o, blue_o}), 32'(exp_rgb));
    drain();
  endtask

  initial begin
    int c0;
    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_px_count", 32'(px_count), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_rgb", 32'({red_o, green_o, blue_o}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Frame of 5, then frame of 3
    fd_count = 0;
    for (int i = 0; i < 5; i++)
      send(3'b111, 8'd0, 3'b000, 8'($urandom), 8'($urandom), 8'($urandom), i == 4);
    drain();
    check("frame5_px_count", 32'(px_count), 32'd5);
    cycle();
    cycle();
    check("frame5_done_pulses", 32'(fd_count), 32'd1);
    fd_count = 0;
    for (int i = 0; i < 3; i++)
      send(3'b000, 8'd0, 3'b000, 8'($urandom), 8'($urandom), 8'($urandom), i == 2);
    drain();
    check("frame3_px_count", 32'(px_count), 32'd3);
    cycle();
    cycle();
    check("frame3_done_pulses", 32'(fd_count), 32'd1);

    // Directed arithmetic points
    direct("gray",     3'b000, 8'd0,   8'd200, 8'd100, 8'd50,  {8'd124, 8'd124, 8'd124});
    direct("thr100",   3'b100, 8'd100, 8'd200, 8'd100, 8'd50,  {8'd255, 8'd255, 8'd255});
    direct("thr130",   3'b100, 8'd130, 8'd200, 8'd100, 8'd50,  {8'd0,   8'd0,   8'd0});
    direct("brighten", 3'b001, 8'd10,  8'd250, 8'd3,   8'd128, {8'd255, 8'd13,  8'd138});
    direct("darken",   3'b010, 8'd10,  8'd5,   8'd10,  8'd200, {8'd0,   8'd0,   8'd190});

    // Back-to-back mode switching at full rate
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      case (i % 3)
        0:       send(3'b011, 8'd0, 3'b000, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        1:       send(3'b101, 8'd0, 3'b010, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        default: send(3'b110, 8'd0, 3'b000, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      endcase
    end
    check("stream_full_rate_cycles", 32'(cyc - c0), 32'd8);
    drain();

    // Output stall of 3 cycles mid-stream
    stall_lo = cyc + 4;
    stall_hi = cyc + 7;
    for (int i = 0; i < 8; i++)
      send(3'($urandom_range(0, 7)), 8'($urandom), 3'($urandom_range(0, 7)),
           8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    drain();
    check("stall_px_count_held", 32'(px_count), 32'd3);

    // Asynchronous reset between edges while the pipe is full
    for (int i = 0; i < 4; i++)
      send(3'b111, 8'd0, 3'b000, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2;
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_px_count", 32'(px_count), 32'd0);
    sb.delete();
    was_stall = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    direct("post_rst_gray", 3'b000, 8'd0, 8'd200, 8'd100, 8'd50, {8'd124, 8'd124, 8'd124});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed simulation still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule
